// File: rtl/regfile_pkg.sv
// ----------------------------------------------------------------------------
// regfile_pkg: shared sizes and types for the FP/integer register files.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package regfile_pkg;

  localparam int FP_ADDR_SIZE  = 5;
  localparam int FP_DATA_SIZE  = 32;
  localparam int INT_DATA_SIZE = 64;

  typedef logic [4:0] reg_addr_t;

endpackage

`default_nettype wire

// File: rtl/register_file_3r1w_decoder.sv
// ----------------------------------------------------------------------------
// register_file_3r1w_decoder: n-to-2^n one-hot decoder with enable.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module register_file_3r1w_decoder
  import regfile_pkg::*;
#(
  parameter int AddrSize = FP_ADDR_SIZE
) (
  input  logic                       i_en,
  input  logic [AddrSize-1:0]        i_addr,
  output logic [(1<<AddrSize)-1:0]   o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) begin
      o_onehot[i_addr] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/register_file_3r1w.sv
// ----------------------------------------------------------------------------
// register_file_3r1w: 2^AddrSize x DataSize register file, 3 comb reads, 1 write.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module register_file_3r1w
  import regfile_pkg::*;
#(
  parameter int AddrSize   = FP_ADDR_SIZE,
  parameter int DataSize   = FP_DATA_SIZE,
  parameter bit HasZeroReg = 1'b0,
  parameter bit BypassEn   = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                we_i,
  input  logic [AddrSize-1:0] wr_addr_i,
  input  logic [DataSize-1:0] wr_data_i,
  input  logic [AddrSize-1:0] rs1_addr_i,
  input  logic [AddrSize-1:0] rs2_addr_i,
  input  logic [AddrSize-1:0] rs3_addr_i,
  output logic [DataSize-1:0] rs1_data_o,
  output logic [DataSize-1:0] rs2_data_o,
  output logic [DataSize-1:0] rs3_data_o,
  input  logic                clear_dirty_i,
  output logic                dirty_o
);

  localparam int NUM_REGS  = 1 << AddrSize;
  localparam int NUM_PORTS = 3;

  logic                w_wr_is_zero;
  logic                w_eff_we;
  logic [NUM_REGS-1:0] w_onehot;
  logic [DataSize-1:0] w_regs    [NUM_REGS];
  logic [AddrSize-1:0] w_rd_addr [NUM_PORTS];
  logic [DataSize-1:0] w_rd_data [NUM_PORTS];
  logic                r_dirty;

  // A write to the hard-wired zero register is dropped before it reaches the decoder.
  assign w_wr_is_zero = (wr_addr_i == '0);
  assign w_eff_we     = we_i && !(HasZeroReg && w_wr_is_zero);

  register_file_3r1w_decoder #(
    .AddrSize (AddrSize)
  ) u_decoder (
    .i_en     (w_eff_we),
    .i_addr   (wr_addr_i),
    .o_onehot (w_onehot)
  );

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_regs
    logic [DataSize-1:0] r_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_q <= '0;
      end else if (w_onehot[k]) begin
        r_q <= wr_data_i;
      end
    end

    assign w_regs[k] = r_q;
  end

  assign w_rd_addr[0] = rs1_addr_i;
  assign w_rd_addr[1] = rs2_addr_i;
  assign w_rd_addr[2] = rs3_addr_i;

  // Zero-register masking takes precedence over the bypass so r0 never leaks write data.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rd_ports
    always_comb begin
      w_rd_data[p] = w_regs[w_rd_addr[p]];
      if (HasZeroReg && (w_rd_addr[p] == '0)) begin
        w_rd_data[p] = '0;
      end else if (BypassEn && we_i && (w_rd_addr[p] == wr_addr_i)) begin
        w_rd_data[p] = wr_data_i;
      end
    end
  end

  assign rs1_data_o = w_rd_data[0];
  assign rs2_data_o = w_rd_data[1];
  assign rs3_data_o = w_rd_data[2];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dirty <= 1'b0;
    end else if (w_eff_we) begin
      r_dirty <= 1'b1;
    end else if (clear_dirty_i) begin
      r_dirty <= 1'b0;
    end
  end

  assign dirty_o = r_dirty;

endmodule

`default_nettype wire
